// File: rtl/radiant_ext_trig_tx_if.sv
// Request/config/status bundle between the trigger overlord and the TRIGOUT transmitter.
// The overlord holds the master side; the transmitter is the slave.
interface radiant_ext_trig_tx_if #(
    parameter int DELAY_WIDTH   = 8,
    parameter int WIDTH_WIDTH   = 8,
    parameter int HOLDOFF_WIDTH = 16
);
    logic                     en_i;
    logic                     trig_i;
    logic [DELAY_WIDTH-1:0]   delay_i;
    logic [WIDTH_WIDTH-1:0]   width_i;
    logic [HOLDOFF_WIDTH-1:0] holdoff_i;
    logic                     cnt_clr_i;
    logic                     ext_trig_o;
    logic                     busy_o;
    logic [31:0]              sent_cnt_o;
    logic [15:0]              drop_cnt_o;

    modport master (
        output en_i, trig_i, delay_i, width_i, holdoff_i, cnt_clr_i,
        input  ext_trig_o, busy_o, sent_cnt_o, drop_cnt_o
    );

    modport slave (
        input  en_i, trig_i, delay_i, width_i, holdoff_i, cnt_clr_i,
        output ext_trig_o, busy_o, sent_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/radiant_ext_trig_tx.sv
// RADIANT TRIGOUT transmitter: one-cycle trigger flag -> delayed, shaped, rate-limited
// line pulse, with sent (wrapping) and dropped (saturating) request counters.
module radiant_ext_trig_tx #(
    parameter int DELAY_WIDTH   = 8,
    parameter int WIDTH_WIDTH   = 8,
    parameter int HOLDOFF_WIDTH = 16,
    parameter bit OUT_INVERT    = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    radiant_ext_trig_tx_if.slave   bus
);
    localparam int DW_MAX = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;
    localparam int CNT_W  = (DW_MAX > HOLDOFF_WIDTH) ? DW_MAX : HOLDOFF_WIDTH;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WIDTH_WIDTH-1:0]   width_q, width_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
    logic [31:0]              sent_q, sent_d;
    logic [15:0]              drop_q, drop_d;
    logic                     ext_trig_q, ext_trig_d;
    logic [CNT_W-1:0]         wlen_in, wlen_sh;
    logic                     drop_req, pulse_entry;

    // Zero width is stretched to a single cycle, both for a direct launch and from the shadow.
    assign wlen_in = (bus.width_i == '0) ? CNT_W'(1) : CNT_W'(bus.width_i);
    assign wlen_sh = (width_q == '0)     ? CNT_W'(1) : CNT_W'(width_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - CNT_W'(1);
        width_d   = width_q;
        holdoff_d = holdoff_q;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (bus.en_i && bus.trig_i) begin
                    width_d   = bus.width_i;
                    holdoff_d = bus.holdoff_i;
                    if (bus.delay_i == '0) begin
                        state_d = PULSE;
                        cnt_d   = wlen_in;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = CNT_W'(bus.delay_i);
                    end
                end
            end
            DELAY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = PULSE;
                    cnt_d   = wlen_sh;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (holdoff_q != '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = CNT_W'(holdoff_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (cnt_q == CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!bus.en_i) state_d = IDLE;
    end

    assign drop_req    = bus.en_i && bus.trig_i && (state_q != IDLE);
    assign pulse_entry = (state_d == PULSE) && (state_q != PULSE);

    always_comb begin
        sent_d = sent_q + (pulse_entry ? 32'd1 : 32'd0);
        drop_d = (drop_req && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
        if (bus.cnt_clr_i) begin
            sent_d = '0;
            drop_d = '0;
        end
    end

    // Line register follows the next state so the pulse lines up with the PULSE state.
    assign ext_trig_d = (state_d == PULSE) ^ OUT_INVERT;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            width_q    <= '0;
            holdoff_q  <= '0;
            sent_q     <= '0;
            drop_q     <= '0;
            ext_trig_q <= OUT_INVERT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            holdoff_q  <= holdoff_d;
            sent_q     <= sent_d;
            drop_q     <= drop_d;
            ext_trig_q <= ext_trig_d;
        end
    end

    assign bus.ext_trig_o = ext_trig_q;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.sent_cnt_o = sent_q;
    assign bus.drop_cnt_o = drop_q;
endmodule
